// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : Execute-to-memory pipeline stage register for the RV32 core.
//                Captures the ALU result, memory/writeback control and a
//                branch decision resolved from the ALU flags. Valid/ready
//                handshakes on both sides, flush support.
//                Build option EX_MEM_SKID_EN: when defined, a 2-entry skid
//                buffer with a registered in_ready; when undefined, a single
//                entry with in_ready = !out_valid || out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg #(
   parameter int XLEN = 32,
   parameter int RDW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic [XLEN-1:0] alu_result,
   input  logic            Zero,
   input  logic            Overflow,
   input  logic            Negative,
   input  logic            Carry,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [RDW-1:0]  rd,
   input  logic            reg_write,
   input  logic            mem_write,
   input  logic [1:0]      result_src,
   input  logic [2:0]      branch_type,
   input  logic [XLEN-1:0] pc_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_result,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [RDW-1:0]  out_rd,
   output logic            out_reg_write,
   output logic            out_mem_write,
   output logic [1:0]      out_result_src,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target
);

   // One held instruction, branch decision already resolved.
   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] rs2_data;
      logic [RDW-1:0]  rd;
      logic            reg_write;
      logic            mem_write;
      logic [1:0]      result_src;
      logic            branch_taken;
      logic [XLEN-1:0] branch_target;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1
`ifdef EX_MEM_SKID_EN
      ,
      S_SKID  = 2'd2
`endif
   } state_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t w_in_entry;
   logic   w_taken;
   logic   w_accept;
   logic   w_transfer;
   logic   w_out_valid;
   logic   w_in_ready;

`ifdef EX_MEM_SKID_EN
   entry_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;
`endif

   // Resolve the branch from the flags of the ALU subtraction a-b.
   always_comb begin
      w_taken = 1'b0;
      case (branch_type)
         3'b000:  w_taken = 1'b0;
         3'b001:  w_taken = Zero;
         3'b010:  w_taken = ~Zero;
         3'b011:  w_taken = Negative ^ Overflow;
         3'b100:  w_taken = ~(Negative ^ Overflow);
         3'b101:  w_taken = 1'b1;
         3'b110:  w_taken = ~Carry;
         3'b111:  w_taken = Carry;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_in_entry = '{
      alu_result:    alu_result,
      rs2_data:      rs2_data,
      rd:            rd,
      reg_write:     reg_write,
      mem_write:     mem_write,
      result_src:    result_src,
      branch_taken:  w_taken,
      branch_target: pc_target
   };

   assign w_out_valid = (state_q != S_EMPTY);
`ifdef EX_MEM_SKID_EN
   assign w_in_ready  = in_ready_q;
`else
   assign w_in_ready  = ~w_out_valid | out_ready;
`endif
   // A flush cycle ignores the presented instruction.
   assign w_accept    = in_valid & w_in_ready & ~flush;
   assign w_transfer  = w_out_valid & out_ready;

   // Next-state logic: FIFO order, main entry always presented first.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef EX_MEM_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (w_accept) begin
                  state_d = S_FULL;
                  main_d  = w_in_entry;
               end
            end
            S_FULL: begin
               if (w_transfer) begin
                  if (w_accept) begin
                     main_d = w_in_entry;
                  end else begin
                     state_d = S_EMPTY;
                  end
               end
`ifdef EX_MEM_SKID_EN
               else if (w_accept) begin
                  state_d = S_SKID;
                  skid_d  = w_in_entry;
               end
`endif
            end
`ifdef EX_MEM_SKID_EN
            S_SKID: begin
               if (w_transfer) begin
                  state_d = S_FULL;
                  main_d  = skid_q;
               end
            end
`endif
            default: state_d = S_EMPTY;
         endcase
      end
`ifdef EX_MEM_SKID_EN
      in_ready_d = (state_d != S_SKID);
`endif
   end

   // State and entry registers; reset overrides flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
`ifdef EX_MEM_SKID_EN
         skid_q     <= '0;
         in_ready_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
`ifdef EX_MEM_SKID_EN
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
`endif
      end
   end

   assign in_ready       = w_in_ready;
   assign out_valid      = w_out_valid;
   assign out_alu_result = main_q.alu_result;
   assign out_rs2_data   = main_q.rs2_data;
   assign out_rd         = main_q.rd;
   assign out_reg_write  = main_q.reg_write;
   assign out_mem_write  = main_q.mem_write;
   assign out_result_src = main_q.result_src;
   assign branch_taken   = main_q.branch_taken;
   assign branch_target  = main_q.branch_target;

endmodule
`default_nettype wire
